tl_sensor_cond: RTL and testbench

//  Upstream stage of the traffic light controller. Conditions raw car-detector inputs into
//  the clean Ta/Tb traffic flags that drive the next-state logic. Each street's detector is

---
 rtl/tl_pkg.sv | 9 +
 rtl/tl_debounce.sv | 48 ++++
 rtl/tl_sensor_cond.sv | 51 +++++
 tb/tb_tl_sensor_cond.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared constants for the traffic light controller: counter widths and output reset values.
package tl_pkg;

    localparam int   TL_TICK_W   = 8;
    localparam int   TL_DEB_W    = 4;
    localparam logic TL_T_RST    = 1'b0;
    localparam logic TL_TICK_RST = 1'b0;

endpackage

// File: rtl/tl_debounce.sv
// One detector channel: two-flop synchroniser followed by a tick-qualified debounce counter.
module tl_debounce
    import tl_pkg::*;
#(
    parameter int DEB = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic tick,
    output logic q
);

    localparam logic [TL_DEB_W-1:0] CNT_LAST = TL_DEB_W'(DEB - 1);

    logic                sync_p0;
    logic                sync_p1;
    logic [TL_DEB_W-1:0] cnt;

    // stage p0/p1: plain flop chain, nothing between the two flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // debounce stage: any agreement cycle clears the count, even on a tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            q   <= TL_T_RST;
        end else if (sync_p1 == q) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt == CNT_LAST) begin
                q   <= sync_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_sensor_cond.sv
// Sensor conditioning: shared tick prescaler plus one debounced channel per street.
module tl_sensor_cond
    import tl_pkg::*;
#(
    parameter int DIV = 4,
    parameter int DEB = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sa_raw,
    input  logic sb_raw,
    output logic Ta,
    output logic Tb,
    output logic tick
);

    localparam logic [TL_TICK_W-1:0] P_LAST = TL_TICK_W'(DIV - 1);

    logic [TL_TICK_W-1:0] p;

    // With DIV=1 P_LAST is 0, so p stays at 0 and tick is high every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p    <= '0;
            tick <= TL_TICK_RST;
        end else if (p == P_LAST) begin
            p    <= '0;
            tick <= 1'b1;
        end else begin
            p    <= p + 1'b1;
            tick <= 1'b0;
        end
    end

    tl_debounce #(.DEB(DEB)) u_deb_a (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sa_raw),
        .tick    (tick),
        .q       (Ta)
    );

    tl_debounce #(.DEB(DEB)) u_deb_b (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sb_raw),
        .tick    (tick),
        .q       (Tb)
    );

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Bench for tl_sensor_cond: DIV=4/DEB=3 and DIV=1/DEB=1 instances driven from shared inputs.
module tb_tl_sensor_cond;

    localparam int DIV0 = 4;
    localparam int DEB0 = 3;
    localparam int DIV1 = 1;
    localparam int DEB1 = 1;

    logic clk;
    logic reset_n;
    logic sa_raw;
    logic sb_raw;
    logic ta0, tb0, tick0;
    logic ta1, tb1, tick1;

    int n_vec = 0;
    int n_err = 0;

    tl_sensor_cond #(.DIV(DIV0), .DEB(DEB0)) dut0 (
        .clk(clk), .reset_n(reset_n), .sa_raw(sa_raw), .sb_raw(sb_raw),
        .Ta(ta0), .Tb(tb0), .tick(tick0)
    );

    tl_sensor_cond #(.DIV(DIV1), .DEB(DEB1)) dut1 (
        .clk(clk), .reset_n(reset_n), .sa_raw(sa_raw), .sb_raw(sb_raw),
        .Ta(ta1), .Tb(tb1), .tick(tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference, instance 0 = DIV0/DEB0, instance 1 = DIV1/DEB1
    bit m_s1   [2][2];
    bit m_s2   [2][2];
    bit m_q    [2][2];
    int m_c    [2][2];
    int m_p    [2];
    bit m_tick [2];

    typedef struct packed {
        logic ta0, tb0, tk0, ta1, tb1, tk1;
    } exp_t;
    exp_t sb_q[$];

    int n_since;
    bit d0, d1, d2;

    typedef struct {
        int a_len;
        int b_len;
        bit exp_a;
        bit exp_b;
        bit same_edge;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[i][c] = 0; m_s2[i][c] = 0; m_q[i][c] = 0; m_c[i][c] = 0;
            end
            m_p[i] = 0;
            m_tick[i] = 0;
        end
    endtask

    task automatic model_step(input bit ra, input bit rb);
        bit rw[2];
        int dv, db;
        rw[0] = ra;
        rw[1] = rb;
        for (int i = 0; i < 2; i++) begin
            dv = (i == 0) ? DIV0 : DIV1;
            db = (i == 0) ? DEB0 : DEB1;
            for (int c = 0; c < 2; c++) begin
                if (m_s2[i][c] == m_q[i][c]) begin
                    m_c[i][c] = 0;
                end else if (m_tick[i]) begin
                    if (m_c[i][c] == db - 1) begin
                        m_q[i][c] = m_s2[i][c];
                        m_c[i][c] = 0;
                    end else begin
                        m_c[i][c] = m_c[i][c] + 1;
                    end
                end
                m_s2[i][c] = m_s1[i][c];
                m_s1[i][c] = rw[c];
            end
            if (m_p[i] == dv - 1) begin
                m_p[i] = 0;
                m_tick[i] = 1;
            end else begin
                m_p[i] = m_p[i] + 1;
                m_tick[i] = 0;
            end
        end
    endtask

    // One clock: update reference at the rising edge, compare at the falling edge
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
            n_since = 0;
        end else begin
            model_step(sa_raw, sb_raw);
            n_since++;
            d2 = d1; d1 = d0; d0 = sa_raw;
        end
        sb_q.push_back('{m_q[0][0], m_q[0][1], m_tick[0], m_q[1][0], m_q[1][1], m_tick[1]});
        @(negedge clk);
        e = sb_q.pop_front();
        chk("scoreboard", int'({ta0, tb0, tick0, ta1, tb1, tick1}), int'(e));
        if (n_since >= 3)
            chk("div1_delay3", int'(ta1), int'(d2));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        vec_t vecs[5];
        int ra, rb, fa, k, rise;

        vecs[0] = '{a_len: 30, b_len: 0,  exp_a: 1, exp_b: 0, same_edge: 0};
        vecs[1] = '{a_len: 0,  b_len: 6,  exp_a: 0, exp_b: 0, same_edge: 0};
        vecs[2] = '{a_len: 8,  b_len: 0,  exp_a: 0, exp_b: 0, same_edge: 0};
        vecs[3] = '{a_len: 12, b_len: 12, exp_a: 1, exp_b: 1, same_edge: 1};
        vecs[4] = '{a_len: 30, b_len: 30, exp_a: 1, exp_b: 1, same_edge: 1};

        n_since = 0;
        d0 = 0; d1 = 0; d2 = 0;
        model_reset();
        reset_n = 1'b0;
        sa_raw  = 1'b1;
        sb_raw  = 1'b1;

        // Reset held with detectors active, then tick phase after release
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("reset_hold", int'({ta0, tb0, tick0}), 0);
        end
        sa_raw  = 1'b0;
        sb_raw  = 1'b0;
        reset_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            chk("tick_phase", int'(tick0), int'(i % 4 == 0));
        end
        idle(20);

        // Table: pulse lengths per street, expected qualification
        foreach (vecs[r]) begin
            ra = -1; rb = -1; fa = -1;
            sa_raw = (vecs[r].a_len > 0);
            sb_raw = (vecs[r].b_len > 0);
            for (int kk = 1; kk <= 60; kk++) begin
                cycle();
                if (ta0 && ra < 0) ra = kk;
                if (tb0 && rb < 0) rb = kk;
                if (ra >= 0 && !ta0 && fa < 0) fa = kk;
                if (kk == vecs[r].a_len) sa_raw = 1'b0;
                if (kk == vecs[r].b_len) sb_raw = 1'b0;
            end
            chk("row_ta_rose", int'(ra >= 0), int'(vecs[r].exp_a));
            chk("row_tb_rose", int'(rb >= 0), int'(vecs[r].exp_b));
            if (vecs[r].exp_a) chk_rng("row_ta_rise_lat", ra, 11, 14);
            if (vecs[r].same_edge) chk("row_same_edge", ra, rb);
            if (vecs[r].a_len >= 30) chk_rng("row_ta_fall_lat", fa - vecs[r].a_len, 11, 14);
        end

        // Short B pulse: never qualifies, counter clears once sync sees the fall
        sb_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("glitch_tb_low", int'(tb0), 0);
        end
        sb_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("glitch_tb_low", int'(tb0), 0);
        end
        chk("glitch_cnt_zero", int'(dut0.u_deb_b.cnt), 0);
        idle(10);

        // Gap of one cycle restarts the count; start at prescaler phase 0
        for (int i = 0; i < 8 && m_p[0] != 0; i++) cycle();
        chk("gap_align", m_p[0], 0);
        sa_raw = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("gap_first_low", int'(ta0), 0);
        end
        sa_raw = 1'b0;
        cycle();
        sa_raw = 1'b1;
        rise = -1;
        for (int kk = 1; kk <= 30; kk++) begin
            cycle();
            if (ta0 && rise < 0) rise = kk;
        end
        chk_rng("gap_rise_lat", rise, 11, 14);
        sa_raw = 1'b0;
        idle(30);

        // Reset in the middle of a count
        sa_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("midrst_pre_low", int'(ta0), 0);
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_immediate", int'({ta0, tb0, tick0}), 0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("midrst_hold", int'(ta0), 0);
        end
        reset_n = 1'b1;
        rise = -1;
        for (int kk = 1; kk <= 30; kk++) begin
            cycle();
            if (ta0 && rise < 0) rise = kk;
        end
        chk_rng("midrst_rise_lat", rise, 11, 14);
        sa_raw = 1'b0;
        idle(30);

        // DIV=1, DEB=1 instance: exact three-clock delay on both edges
        sa_raw = 1'b1;
        k = -1;
        for (int kk = 1; kk <= 10; kk++) begin
            cycle();
            if (ta1 && k < 0) k = kk;
        end
        chk("div1_rise_lat", k, 3);
        sa_raw = 1'b0;
        k = -1;
        for (int kk = 1; kk <= 10; kk++) begin
            cycle();
            if (!ta1 && k < 0) k = kk;
        end
        chk("div1_fall_lat", k, 3);
        for (int i = 0; i < 40; i++) begin
            sa_raw = 1'($urandom_range(0, 1));
            sb_raw = 1'($urandom_range(0, 1));
            cycle();
        end
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
